// File: rtl/branch_redirect_pkg.sv
// Shared constants and helpers for the branch redirect unit: opcodes, BHT reset value,
// immediate extraction and the 2-bit saturating counter step.
package branch_redirect_pkg;

  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [1:0] BHT_RST_VAL = 2'b01;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: array of 2-bit saturating counters with one combinational read
// port and one saturating update port. Reads see the pre-update value (no bypass).
module bp_bht
  import branch_redirect_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [1:0] ctr_q [Entries];

  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= BHT_RST_VAL;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_redirect.sv
// Next-PC redirect logic: fetch-stage static/BHT prediction, EX-stage misprediction
// recovery, a two-cycle pipeline flush and branch/redirect statistics counters.
module branch_redirect
  import branch_redirect_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid_i,
  input  logic [31:0] f_pc_i,
  input  logic [31:0] f_instr_i,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_is_jalr_i,
  input  logic        ex_taken_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  output logic        pc_jump_o,
  output logic [31:0] pc_i_jump_o,
  output logic        predict_miss_o,
  output logic [31:0] pc_not_jump_o,
  output logic        f_pred_taken_o,
  output logic        flush_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] miss_cnt_o
);

  logic        state_q, state_d;
  logic        flush_busy;
  logic        is_b, is_jal;
  logic [31:0] fetch_tgt;
  logic [1:0]  bht_ctr;
  logic        fetch_pred;
  logic        ex_live, ex_br_upd;
  logic        ex_redirect_t, ex_redirect_nt, ex_redirect;
  logic [31:0] br_cnt_q, miss_cnt_q;

  assign flush_busy = (state_q == ST_FLUSH);
  assign is_b       = (f_instr_i[6:0] == OPC_BRANCH);
  assign is_jal     = (f_instr_i[6:0] == OPC_JAL);
  assign fetch_tgt  = f_pc_i + (is_jal ? imm_j(f_instr_i) : imm_b(f_instr_i));

  bp_bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (f_pc_i[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .upd_en   (ex_br_upd),
    .upd_idx  (ex_pc_i[BHT_IDX_W+1:2]),
    .upd_taken(ex_taken_i)
  );

  // Gating with ~rst keeps every redirect output quiet while reset is held.
  assign ex_live        = ex_valid_i & ~flush_busy & ~rst;
  assign ex_br_upd      = ex_live & ex_is_branch_i;
  assign ex_redirect_t  = ex_live & (ex_is_jalr_i | (ex_is_branch_i & ex_taken_i & ~ex_pred_taken_i));
  assign ex_redirect_nt = ex_live & ex_is_branch_i & ~ex_taken_i & ex_pred_taken_i;
  assign ex_redirect    = ex_redirect_t | ex_redirect_nt;

  assign fetch_pred = f_valid_i & ~stall_i & ~flush_busy & ~ex_redirect & ~rst &
                      (is_jal | (is_b & bht_ctr[1]));

  assign f_pred_taken_o = fetch_pred;
  assign pc_jump_o      = ex_redirect_t | fetch_pred;
  assign pc_i_jump_o    = ex_redirect_t ? ex_target_i : (fetch_pred ? fetch_tgt : 32'h0);
  assign predict_miss_o = ex_redirect_nt;
  assign pc_not_jump_o  = ex_redirect_nt ? ex_pc_i : 32'h0;
  assign flush_o        = (ex_redirect | flush_busy) & ~rst;

  always_comb begin
    state_d = ST_IDLE;
    if (!flush_busy && ex_redirect) state_d = ST_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      br_cnt_q   <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (ex_br_upd && (br_cnt_q != 32'hFFFF_FFFF))     br_cnt_q   <= br_cnt_q + 32'd1;
      if (ex_redirect && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/branch_redirect.md
BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 Parameter: BHT_IDX_W, default 4, log2 of branch-history-table entries (16).
REQ-002 Ports: clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 f_valid_i  input  1  fetch instruction valid; f_pc_i  input  32  fetch PC; f_instr_i  input  32  instruction at f_pc_i.
REQ-005 stall_i  input  1  load-use stall active (either stall flavour, ORed upstream).
REQ-006 ex_valid_i  input  1; ex_is_branch_i  input  1  conditional branch; ex_is_jalr_i  input  1; ex_taken_i  input  1  resolved outcome; ex_pred_taken_i  input  1  fetch prediction carried down the pipe.
REQ-007 ex_pc_i  input  32  EX instruction PC; ex_target_i  input  32  resolved target.
REQ-008 pc_jump_o  output  1; pc_i_jump_o  output  32  next-PC when pc_jump_o=1.
REQ-009 predict_miss_o  output  1; pc_not_jump_o  output  32  PC of mispredicted branch (fetch restarts at it +4).
REQ-010 f_pred_taken_o  output  1  prediction for the fetched instruction; flush_o  output  1  kill IF/ID and ID/EX.
REQ-011 br_cnt_o  output  32  resolved branches; miss_cnt_o  output  32  redirects from EX.

Function
REQ-012 Decode at fetch: B-type opcode 7'b1100011, JAL opcode 7'b1101111, on f_instr_i[6:0].
REQ-013 Fetch target: f_pc_i + sign-extended B or J immediate (bit 0 = 0), mod 2^32.
REQ-014 BHT: 2^BHT_IDX_W 2-bit saturating counters; fetch index f_pc_i[BHT_IDX_W+1:2], update index ex_pc_i[BHT_IDX_W+1:2]; predict taken when counter[1]=1.
REQ-015 fetch_pred = f_valid_i & ~stall_i & ~flush_busy & ~ex_redirect & (JAL | (B-type & counter[1])); f_pred_taken_o = fetch_pred.
REQ-016 ex_live = ex_valid_i & ~flush_busy.
REQ-017 ex_redirect_t = ex_live & (ex_is_jalr_i | (ex_is_branch_i & ex_taken_i & ~ex_pred_taken_i)).
REQ-018 ex_redirect_nt = ex_live & ex_is_branch_i & ~ex_taken_i & ex_pred_taken_i; ex_redirect = ex_redirect_t | ex_redirect_nt.
REQ-019 pc_jump_o = ex_redirect_t | fetch_pred; pc_i_jump_o = ex_target_i if ex_redirect_t, else fetch target, else 0.
REQ-020 predict_miss_o = ex_redirect_nt; pc_not_jump_o = ex_pc_i when asserted, else 0.
REQ-021 pc_jump_o and predict_miss_o SHALL never be high in the same cycle; EX redirect always overrides fetch prediction.
REQ-022 All redirect outputs combinational, same cycle as cause (zero latency to PC register).
REQ-023 Flush FSM IDLE/FLUSH: IDLE->FLUSH on ex_redirect, FLUSH->IDLE after one cycle; flush_busy = (state==FLUSH).
REQ-024 flush_o = ex_redirect | flush_busy (two-cycle pulse per EX redirect).
REQ-025 A new ex_redirect cannot occur in FLUSH (ex_live=0); fetch prediction suppressed in FLUSH.
REQ-026 BHT update on ex_live & ex_is_branch_i: increment (sat 3) if ex_taken_i, else decrement (sat 0).
REQ-027 Same-index fetch read and EX write in one cycle: fetch reads pre-update value, no bypass.
REQ-028 br_cnt_o += 1 on ex_live & ex_is_branch_i; miss_cnt_o += 1 on ex_redirect; both saturate at 32'hFFFF_FFFF.
REQ-029 stall_i does not block EX resolution or BHT update.

Reset
REQ-030 On rst high at a clock edge: all BHT counters 2'b01, FSM IDLE, br_cnt_o=0, miss_cnt_o=0.
REQ-031 While rst high: pc_jump_o, predict_miss_o, f_pred_taken_o, flush_o = 0; pc_i_jump_o, pc_not_jump_o = 0.
REQ-032 Reset mid-FLUSH returns to IDLE with no residual flush_o.

Structure
REQ-033 Shared package: opcode constants, BHT reset value 2'b01, immediate-extract functions.
REQ-034 One sub-module bp_bht: counter array, one read port, one saturating update port.

Verification
REQ-035 After reset, f_pc=0x100, BEQ imm=+16 -> counter 01, pc_jump_o=0, f_pred_taken_o=0.
REQ-036 JAL at f_pc=0x200, imm=+0x40 -> pc_jump_o=1, pc_i_jump_o=0x240 same cycle; with stall_i=1 -> pc_jump_o=0.
REQ-037 EX branch pc=0x100 taken, pred=0, target=0x110 -> pc_jump_o=1, pc_i_jump_o=0x110, flush_o high 2 cycles, miss_cnt_o=1, counter[0] 01->10.
REQ-038 EX branch pc=0x300 not taken, pred=1 -> predict_miss_o=1, pc_not_jump_o=0x300; concurrent fetch JAL ignored (pc_jump_o=0).
REQ-039 EX valid branch in cycle after a redirect -> ignored: no BHT change, no count, no redirect.
REQ-040 Four taken resolutions of one index -> counter saturates at 3; five not-taken -> 0; rst mid-FLUSH -> flush_o=0 next cycle.
